// File: rtl/width_conv_buffer_pkg.sv
// rtl/width_conv_buffer_pkg.sv - shared sizing and sub-word ordering helpers
package width_conv_buffer_pkg;

    function automatic int calc_uw(input int depth, input int ratio);
        return $clog2(depth * ratio + 1);
    endfunction

    function automatic int sub_slice(input int k, input int ratio, input bit msb_first);
        return msb_first ? (ratio - 1 - k) : k;
    endfunction

endpackage

// File: rtl/width_conv_buffer_if.sv
// rtl/width_conv_buffer_if.sv - write/read handshake bundle of the width converter
interface width_conv_buffer_if #(
    parameter int OUT_W = 8,
    parameter int RATIO = 2
);
    logic                     wrreq;
    logic [OUT_W*RATIO-1:0]   input_data;
    logic                     rdreq;
    logic [OUT_W-1:0]         output_data;
    logic                     output_valid;

    modport master (
        output wrreq, input_data, rdreq,
        input  output_data, output_valid
    );

    modport slave (
        input  wrreq, input_data, rdreq,
        output output_data, output_valid
    );
endinterface

// File: rtl/width_conv_buffer_ram.sv
// rtl/width_conv_buffer_ram.sv - simple dual-port RAM, synchronous write-first read
module wcb_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];

    // Write-first so a word written into an empty buffer is visible to the next read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o <= wdata_i;
        end else begin
            rdata_o <= mem[raddr_i];
        end
    end
endmodule

// File: rtl/width_conv_buffer.sv
// rtl/width_conv_buffer.sv - wide-in / narrow-out buffer with occupancy, threshold ready and sticky flags
module width_conv_buffer
    import width_conv_buffer_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 64,
    parameter int HYST      = 0,
    parameter int MSB_FIRST = 0,
    localparam int UW       = calc_uw(DEPTH, RATIO)
) (
    input  logic                 rdclk,
    input  logic                 arst,
    input  logic                 clr,
    width_conv_buffer_if.slave   bus,
    input  logic [UW-1:0]        thresh,
    output logic [UW-1:0]        usedw,
    output logic                 output_ready,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int IN_W = OUT_W * RATIO;
    localparam int AW   = $clog2(DEPTH);
    localparam int SW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0] LAST_SUB = SW'(RATIO - 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]    sub_q, sub_d;
    logic [AW:0]      ent_q, ent_d;
    logic [UW-1:0]    usedw_q, usedw_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             ready_q, ready_d, valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [IN_W-1:0]  ram_q;
    logic             wr_ok, rd_ok, rd_last;
    int               sel;

    assign wr_ok   = bus.wrreq && !full_q && !clr;
    assign rd_ok   = bus.rdreq && !empty_q && !clr;
    assign rd_last = rd_ok && (sub_q == LAST_SUB);
    assign sel     = sub_slice(int'(sub_q), RATIO, MSB_FIRST != 0);

    // RAM reads the next-state pointer, so ram_q always holds the entry at rd_ptr_q.
    wcb_ram #(.W(IN_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (rdclk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.input_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_q)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sub_d    = sub_q;
        data_d   = data_q;
        valid_d  = rd_ok;
        ovf_d    = ovf_q | (bus.wrreq && full_q);
        unf_d    = unf_q | (bus.rdreq && empty_q);

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            data_d = ram_q[sel*OUT_W +: OUT_W];
            sub_d  = rd_last ? '0 : sub_q + SW'(1);
            if (rd_last) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
        end

        ent_d   = ent_q + (AW+1)'(wr_ok) - (AW+1)'(rd_last);
        usedw_d = usedw_q + (wr_ok ? UW'(RATIO) : '0) - (rd_ok ? UW'(1) : '0);
        full_d  = (ent_d == (AW+1)'(DEPTH));
        empty_d = (usedw_d == '0);

        // With no hysteresis the flag is a plain strict compare against thresh.
        if (HYST == 0) begin
            ready_d = (usedw_q > thresh);
        end else if (usedw_q > thresh) begin
            ready_d = 1'b1;
        end else if (({1'b0, usedw_q} + (UW+1)'(HYST)) < {1'b0, thresh}) begin
            ready_d = 1'b0;
        end else begin
            ready_d = ready_q;
        end

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            sub_d    = '0;
            ent_d    = '0;
            usedw_d  = '0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            ready_d  = 1'b0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge rdclk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sub_q    <= '0;
            ent_q    <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sub_q    <= sub_d;
            ent_q    <= ent_d;
            usedw_q  <= usedw_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign bus.output_data  = data_q;
    assign bus.output_valid = valid_q;
    assign usedw            = usedw_q;
    assign output_ready     = ready_q;
    assign full             = full_q;
    assign empty            = empty_q;
    assign overflow         = ovf_q;
    assign underflow        = unf_q;
endmodule

// File: tb/tb_width_conv_buffer.sv
// tb/tb_width_conv_buffer.sv - directed vector bench for width_conv_buffer
module tb_width_conv_buffer;
    localparam int UW = 8;

    logic          clk;
    logic          arst;
    logic [2:0]    clr;
    logic [UW-1:0] thresh [3];
    logic [UW-1:0] usedw [3];
    logic [2:0]    ready, full, empty, ovf, unf;

    width_conv_buffer_if #(.OUT_W(8), .RATIO(2)) if0 ();
    width_conv_buffer_if #(.OUT_W(8), .RATIO(2)) if1 ();
    width_conv_buffer_if #(.OUT_W(8), .RATIO(2)) if2 ();

    width_conv_buffer #(.OUT_W(8), .RATIO(2), .DEPTH(64), .HYST(0), .MSB_FIRST(0)) u0 (
        .rdclk(clk), .arst(arst), .clr(clr[0]), .bus(if0), .thresh(thresh[0]),
        .usedw(usedw[0]), .output_ready(ready[0]), .full(full[0]), .empty(empty[0]),
        .overflow(ovf[0]), .underflow(unf[0]));

    width_conv_buffer #(.OUT_W(8), .RATIO(2), .DEPTH(64), .HYST(0), .MSB_FIRST(1)) u1 (
        .rdclk(clk), .arst(arst), .clr(clr[1]), .bus(if1), .thresh(thresh[1]),
        .usedw(usedw[1]), .output_ready(ready[1]), .full(full[1]), .empty(empty[1]),
        .overflow(ovf[1]), .underflow(unf[1]));

    width_conv_buffer #(.OUT_W(8), .RATIO(2), .DEPTH(64), .HYST(4), .MSB_FIRST(0)) u2 (
        .rdclk(clk), .arst(arst), .clr(clr[2]), .bus(if2), .thresh(thresh[2]),
        .usedw(usedw[2]), .output_ready(ready[2]), .full(full[2]), .empty(empty[2]),
        .overflow(ovf[2]), .underflow(unf[2]));

    typedef struct {
        bit          wr;
        logic [15:0] din;
        bit          rd;
        bit          cl;
        bit          v;
        logic [7:0]  d;
        int          u;
        bit          e;
        bit          f;
        bit          r;
        bit          o;
        bit          un;
    } vec_t;

    vec_t tbl [15];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_u0(input string tag, input vec_t t);
        chk({tag, " valid"}, 32'(if0.output_valid), 32'(t.v));
        chk({tag, " data"}, 32'(if0.output_data), 32'(t.d));
        chk({tag, " usedw"}, 32'(usedw[0]), t.u);
        chk({tag, " empty"}, 32'(empty[0]), 32'(t.e));
        chk({tag, " full"}, 32'(full[0]), 32'(t.f));
        chk({tag, " ready"}, 32'(ready[0]), 32'(t.r));
        chk({tag, " overflow"}, 32'(ovf[0]), 32'(t.o));
        chk({tag, " underflow"}, 32'(unf[0]), 32'(t.un));
    endtask

    function automatic logic [15:0] wordf(input int i);
        return {8'(i ^ 'h5A), 8'(i)};
    endfunction

    initial begin
        vec_t rst_v;
        // {wr, din, rd, clr, valid, data, usedw, empty, full, ready, overflow, underflow}
        tbl[0]  = '{1, 16'hA1B2, 0, 0, 0, 8'h00, 2,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 16'h0000, 1, 0, 1, 8'hB2, 1,  0, 0, 0, 0, 0};
        tbl[2]  = '{0, 16'h0000, 1, 0, 1, 8'hA1, 0,  1, 0, 0, 0, 0};
        tbl[3]  = '{0, 16'h0000, 0, 0, 0, 8'hA1, 0,  1, 0, 0, 0, 0};
        tbl[4]  = '{1, 16'hC3D4, 1, 0, 0, 8'hA1, 2,  0, 0, 0, 0, 1};
        tbl[5]  = '{0, 16'h0000, 0, 1, 0, 8'hA1, 0,  1, 0, 0, 0, 0};
        tbl[6]  = '{1, 16'h5010, 0, 0, 0, 8'hA1, 2,  0, 0, 0, 0, 0};
        tbl[7]  = '{1, 16'h5111, 0, 0, 0, 8'hA1, 4,  0, 0, 0, 0, 0};
        tbl[8]  = '{1, 16'h5212, 0, 0, 0, 8'hA1, 6,  0, 0, 0, 0, 0};
        tbl[9]  = '{1, 16'h5313, 0, 0, 0, 8'hA1, 8,  0, 0, 0, 0, 0};
        tbl[10] = '{1, 16'h5414, 0, 0, 0, 8'hA1, 10, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 16'h0000, 0, 0, 0, 8'hA1, 10, 0, 0, 1, 0, 0};
        tbl[12] = '{0, 16'h0000, 1, 0, 1, 8'h10, 9,  0, 0, 1, 0, 0};
        tbl[13] = '{0, 16'h0000, 0, 0, 0, 8'h10, 9,  0, 0, 0, 0, 0};
        tbl[14] = '{0, 16'h0000, 0, 1, 0, 8'h10, 0,  1, 0, 0, 0, 0};
        rst_v   = '{0, 16'h0000, 0, 0, 0, 8'h00, 0,  1, 0, 0, 0, 0};

        arst = 1'b0;
        clr  = '0;
        for (int k = 0; k < 3; k++) thresh[k] = UW'(9);
        if0.wrreq = 0; if0.rdreq = 0; if0.input_data = '0;
        if1.wrreq = 0; if1.rdreq = 0; if1.input_data = '0;
        if2.wrreq = 0; if2.rdreq = 0; if2.input_data = '0;
        repeat (3) step();
        chk_u0("reset", rst_v);
        arst = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            if0.wrreq      = tbl[i].wr;
            if0.input_data = tbl[i].din;
            if0.rdreq      = tbl[i].rd;
            clr[0]         = tbl[i].cl;
            step();
            if0.wrreq = 0; if0.rdreq = 0; clr[0] = 0;
            chk_u0($sformatf("vec%0d", i), tbl[i]);
        end

        // MSB-first ordering
        if1.wrreq = 1; if1.input_data = 16'h1234;
        step();
        if1.wrreq = 0; if1.rdreq = 1;
        step();
        chk("msb first sub", 32'(if1.output_data), 32'h12);
        chk("msb first valid", 32'(if1.output_valid), 1);
        step();
        if1.rdreq = 0;
        chk("msb second sub", 32'(if1.output_data), 32'h34);
        chk("msb empty", 32'(empty[1]), 1);

        // Hysteresis: thresh 9, HYST 4
        for (int i = 0; i < 6; i++) begin
            if2.wrreq = 1; if2.input_data = 16'(i);
            step();
        end
        if2.wrreq = 0;
        step();
        chk("hyst usedw full", 32'(usedw[2]), 12);
        chk("hyst ready high", 32'(ready[2]), 1);
        for (int k = 11; k >= 0; k--) begin
            if2.rdreq = 1;
            step();
            chk($sformatf("hyst usedw %0d", k), 32'(usedw[2]), k);
            chk($sformatf("hyst ready at %0d", k), 32'(ready[2]), (k >= 4) ? 1 : 0);
        end
        if2.rdreq = 0;

        // Fill to capacity, overflow, drain, underflow
        for (int i = 0; i < 64; i++) begin
            if0.wrreq = 1; if0.input_data = wordf(i);
            step();
        end
        chk("fill full", 32'(full[0]), 1);
        chk("fill usedw", 32'(usedw[0]), 128);
        chk("fill overflow clear", 32'(ovf[0]), 0);
        if0.input_data = 16'hFFFF;
        step();
        if0.wrreq = 0;
        chk("ovf flag", 32'(ovf[0]), 1);
        chk("ovf full", 32'(full[0]), 1);
        chk("ovf usedw", 32'(usedw[0]), 128);
        if0.rdreq = 1;
        for (int j = 0; j < 128; j++) begin
            logic [15:0] w;
            w = wordf(j / 2);
            step();
            chk($sformatf("drain data %0d", j), 32'(if0.output_data), (j % 2 == 0) ? 32'(w[7:0]) : 32'(w[15:8]));
            if (j == 1) chk("drain not full", 32'(full[0]), 0);
        end
        chk("drain usedw", 32'(usedw[0]), 0);
        chk("drain empty", 32'(empty[0]), 1);
        chk("drain no underflow", 32'(unf[0]), 0);
        step();
        if0.rdreq = 0;
        chk("underflow flag", 32'(unf[0]), 1);
        chk("underflow no valid", 32'(if0.output_valid), 0);

        // clr mid-stream at usedw = 7
        for (int i = 0; i < 4; i++) begin
            if0.wrreq = 1; if0.input_data = 16'hBEEF + 16'(i);
            step();
        end
        if0.wrreq = 0; if0.rdreq = 1;
        step();
        if0.rdreq = 0;
        chk("pre clr usedw", 32'(usedw[0]), 7);
        chk("pre clr data", 32'(if0.output_data), 32'hEF);
        clr[0] = 1;
        step();
        clr[0] = 0;
        chk("clr usedw", 32'(usedw[0]), 0);
        chk("clr empty", 32'(empty[0]), 1);
        chk("clr overflow", 32'(ovf[0]), 0);
        chk("clr underflow", 32'(unf[0]), 0);
        chk("clr data kept", 32'(if0.output_data), 32'hEF);

        // Asynchronous reset with a write pending
        if0.wrreq = 1; if0.input_data = 16'h7788;
        step();
        if0.wrreq = 0; if0.rdreq = 1;
        step();
        if0.rdreq = 0; if0.wrreq = 1; if0.input_data = 16'h1234;
        #2 arst = 1'b0;
        #1;
        chk("arst data", 32'(if0.output_data), 0);
        chk("arst usedw", 32'(usedw[0]), 0);
        chk("arst empty", 32'(empty[0]), 1);
        chk("arst full", 32'(full[0]), 0);
        chk("arst valid", 32'(if0.output_valid), 0);
        repeat (2) step();
        if0.wrreq = 0;
        arst = 1'b1;
        step();
        chk("post arst usedw", 32'(usedw[0]), 0);
        chk("post arst empty", 32'(empty[0]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/width_conv_buffer.md
Name: width_conv_buffer

Overview:
- Parametrised single-clock buffer for the transmitter input path.
- Accepts IN_W-bit words and returns OUT_W-bit sub-words in a fixed order.
- Reports occupancy in output words, with a registered ready flag driven by a programmable threshold and hysteresis.
- Adds full/empty status, sticky overflow/underflow flags and a synchronous flush. Data arrives already in the rdclk domain.

Parameters:
- OUT_W, 8: output word width in bits.
- RATIO, 2: sub-words per input word; IN_W = OUT_W*RATIO; RATIO >= 1.
- DEPTH, 64: storage depth in input words; power of two, >= 2.
- HYST, 0: hysteresis in output words below THRESH before ready deasserts.
- MSB_FIRST, 0: 0 = least-significant sub-word is read first; 1 = most-significant first.

Ports:
- rdclk, in, 1: sole clock; all logic is on its rising edge.
- arst, in, 1: reset, asynchronous, active-low.
- clr, in, 1: synchronous flush; empties storage and clears the sticky flags.
- wrreq, in, 1: write one input word this cycle.
- input_data, in, OUT_W*RATIO: write data.
- rdreq, in, 1: read one output sub-word this cycle.
- thresh, in, UW: ready threshold in output words. UW = $clog2(DEPTH*RATIO+1).
- output_data, out, OUT_W: registered read data.
- output_valid, out, 1: output_data is valid this cycle.
- output_ready, out, 1: occupancy is above the threshold, with hysteresis.
- usedw, out, UW: occupancy in output words.
- full, out, 1: DEPTH input words are resident (partially read word counts).
- empty, out, 1: usedw == 0.
- overflow, out, 1: sticky; a write was dropped.
- underflow, out, 1: sticky; a read was ignored.

Behaviour:
- Reset state (arst low, asynchronous):
  - Pointers, sub-index and usedw = 0.
  - output_data = 0, output_valid = 0, output_ready = 0.
  - overflow = 0, underflow = 0; empty = 1, full = 0.
- Write:
  - Accepted when wrreq && !full; stores input_data at the write pointer.
  - Write pointer wraps modulo DEPTH; usedw increases by RATIO.
  - wrreq && full drops the word, sets overflow, and changes no other state.
- Read:
  - Accepted when rdreq && !empty, using the pre-update state.
  - Sub-word order: sub-index 0..RATIO-1 selects bits [k*OUT_W +: OUT_W] (LSB-first), or the mirrored slice when MSB_FIRST = 1.
  - The sub-index advances per read. On the last sub-word, the sub-index returns to 0 and the read pointer advances modulo DEPTH, freeing the entry.
  - usedw decreases by 1 per accepted read.
  - rdreq && empty sets underflow and is otherwise ignored.
- Latency:
  - output_data and output_valid appear 1 cycle after an accepted read.
  - output_valid is a 1-cycle pulse; output_data holds its value between reads.
- Simultaneous events:
  - Write and read in the same cycle are both evaluated against pre-update state.
  - Write into an empty buffer plus rdreq in the same cycle: write accepted, read is an underflow. There is no fall-through.
  - Read of the last sub-word while full, plus wrreq: the write is still dropped, because full is evaluated pre-update.
  - Net usedw change = +RATIO*wr − rd.
- full, empty and usedw are registered and consistent with each other every cycle.
- output_ready, registered, evaluated each cycle from the pre-update usedw (1-cycle lag):
  - Set when usedw > thresh.
  - Cleared when usedw + HYST < thresh, computed in UW+1 bits.
  - Otherwise holds its value.
  - With HYST = 0 it behaves as usedw > thresh, with the 1-cycle lag.
- clr:
  - Highest priority; wrreq and rdreq are ignored in that cycle.
  - Next cycle: same state as reset, except that output_data keeps its last value.
- Arithmetic:
  - usedw is never negative and never exceeds DEPTH*RATIO.
  - Pointers are $clog2(DEPTH) bits; an extra wrap bit or an entry counter distinguishes full from empty.
- Reset asserted mid-transfer discards all content immediately and without glitch on the registered outputs.

Decomposition:
- Shared package: UW computation function, sub-word select function (slice index given MSB_FIRST).
- One sub-module, wcb_ram: DEPTH x IN_W simple dual-port RAM with synchronous read, no reset on the array. The control logic stays in the top.

Test Plan:
- Reset, then write 16'hA1B2 and read twice (defaults) -> output_data = 8'hB2 then 8'hA1, each one cycle after its rdreq; usedw goes 2, 1, 0; empty = 1 at the end.
- MSB_FIRST = 1, write 16'h1234, read x2 -> output_data = 8'h12 then 8'h34.
- thresh = 9, HYST = 0, write 5 words -> output_ready rises one cycle after usedw reaches 10. One read -> falls one cycle after usedw = 9.
- HYST = 4, thresh = 9: fill to usedw = 12, then read down -> output_ready stays 1 through usedw = 5 and drops one cycle after usedw = 4.
- Fill with 64 words, then wrreq with 16'hFFFF -> full = 1, overflow = 1, usedw = 128. Drain 128 reads -> data matches the first 64 words; the 129th rdreq sets underflow.
- Mid-stream: clr pulse while usedw = 7 -> next cycle usedw = 0, flags cleared. Then arst low with wrreq high -> all outputs at reset values, nothing stored.
